// File: rtl/usb_tx_data_buffer.sv
// Byte FIFO between the AHB slave and the USB TX packet engine: 1-4 byte writes, 1 byte pops, FWFT head.
// Optional packet replay/commit support is enabled with the USB_TX_BUF_REPLAY_EN macro.
module usb_tx_data_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        store_tx_data,
    input  logic [31:0] tx_data,
    input  logic [2:0]  tx_byte_cnt,
    input  logic        clear,
    input  logic        get_tx_packet_data,
`ifdef USB_TX_BUF_REPLAY_EN
    input  logic        replay,
    input  logic        commit,
`endif
    output logic [7:0]  tx_packet_data,
    output logic [6:0]  tx_packet_data_size,
    output logic        buffer_full,
    output logic        overflow_err,
    output logic        underflow_err
);

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wptr_r, rptr_r, wptr_next_s, rptr_next_s;
    logic [6:0]        occ_r, occ_next_s, held_s, free_s, wr_n_s, add_s;
    logic              wr_req_s, wr_ok_s, pop_ok_s, unf_next_s;
    logic              full_r, ovf_r, unf_r;

`ifdef USB_TX_BUF_REPLAY_EN
    logic [ADDR_W-1:0] start_r, start_next_s;
    logic [6:0]        held_r, held_next_s;
    assign held_s = held_r;
`else
    assign held_s = occ_r;
`endif

    assign tx_packet_data_size = occ_r;
    assign buffer_full         = full_r;
    assign overflow_err        = ovf_r;
    assign underflow_err       = unf_r;

    // Write admission: the space check uses the occupancy before any pop this cycle
    always_comb begin
        wr_n_s   = {4'd0, tx_byte_cnt};
        free_s   = DEPTH_C - held_s;
        wr_req_s = store_tx_data && (tx_byte_cnt >= 3'd1) && (tx_byte_cnt <= 3'd4) && !clear;
        wr_ok_s  = wr_req_s && (wr_n_s <= free_s);
        if (wr_ok_s) begin
            add_s = wr_n_s;
        end else begin
            add_s = 7'd0;
        end
    end

    // Next pointer / occupancy with clear taking priority over everything
    always_comb begin
        wptr_next_s = wptr_r;
        rptr_next_s = rptr_r;
        occ_next_s  = occ_r;
        pop_ok_s    = 1'b0;
        unf_next_s  = 1'b0;
`ifdef USB_TX_BUF_REPLAY_EN
        start_next_s = start_r;
        held_next_s  = held_r;
`endif
        if (clear) begin
            wptr_next_s = {ADDR_W{1'b0}};
            rptr_next_s = {ADDR_W{1'b0}};
            occ_next_s  = 7'd0;
`ifdef USB_TX_BUF_REPLAY_EN
            start_next_s = {ADDR_W{1'b0}};
            held_next_s  = 7'd0;
`endif
        end else begin
            wptr_next_s = wptr_r + ADDR_W'(add_s);
`ifdef USB_TX_BUF_REPLAY_EN
            if (replay) begin
                rptr_next_s = start_r;
                occ_next_s  = held_r + add_s;
                held_next_s = held_r + add_s;
            end else if (commit) begin
                start_next_s = rptr_r;
                occ_next_s   = occ_r + add_s;
                held_next_s  = occ_r + add_s;
            end else begin
                pop_ok_s    = get_tx_packet_data && (occ_r != 7'd0);
                unf_next_s  = get_tx_packet_data && (occ_r == 7'd0);
                rptr_next_s = rptr_r + ADDR_W'(pop_ok_s);
                occ_next_s  = occ_r + add_s - 7'(pop_ok_s);
                held_next_s = held_r + add_s;
            end
`else
            pop_ok_s    = get_tx_packet_data && (occ_r != 7'd0);
            unf_next_s  = get_tx_packet_data && (occ_r == 7'd0);
            rptr_next_s = rptr_r + ADDR_W'(pop_ok_s);
            occ_next_s  = occ_r + add_s - 7'(pop_ok_s);
`endif
        end
    end

    // Control registers and registered status outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_r <= {ADDR_W{1'b0}};
            rptr_r <= {ADDR_W{1'b0}};
            occ_r  <= 7'd0;
            full_r <= 1'b0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
`ifdef USB_TX_BUF_REPLAY_EN
            start_r <= {ADDR_W{1'b0}};
            held_r  <= 7'd0;
`endif
        end else begin
            wptr_r <= wptr_next_s;
            rptr_r <= rptr_next_s;
            occ_r  <= occ_next_s;
            full_r <= (occ_next_s == DEPTH_C);
            ovf_r  <= wr_req_s && !wr_ok_s;
            unf_r  <= unf_next_s;
`ifdef USB_TX_BUF_REPLAY_EN
            start_r <= start_next_s;
            held_r  <= held_next_s;
`endif
        end
    end

    // Byte storage: little-endian lanes land at consecutive wrapped addresses
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_ok_s && (3'(i) < tx_byte_cnt)) begin
                mem_r[wptr_r + ADDR_W'(i)] <= tx_data[8*i +: 8];
            end
        end
    end

    // FWFT head byte, forced to zero while empty
    always_comb begin
        if (occ_r != 7'd0) begin
            tx_packet_data = mem_r[rptr_r];
        end else begin
            tx_packet_data = 8'h00;
        end
    end

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Self-checking bench for usb_tx_data_buffer: queue-based reference model plus directed literal checks.
module tb_usb_tx_data_buffer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        store_tx_data = 1'b0;
    logic [31:0] tx_data = 32'd0;
    logic [2:0]  tx_byte_cnt = 3'd0;
    logic        clear = 1'b0;
    logic        get_tx_packet_data = 1'b0;
    logic [7:0]  tx_packet_data;
    logic [6:0]  tx_packet_data_size;
    logic        buffer_full;
    logic        overflow_err;
    logic        underflow_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       e_ovf = 1'b0;
    logic       e_unf = 1'b0;
    logic       chk_en = 1'b0;

    usb_tx_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .n_rst(n_rst), .store_tx_data(store_tx_data), .tx_data(tx_data),
        .tx_byte_cnt(tx_byte_cnt), .clear(clear), .get_tx_packet_data(get_tx_packet_data),
        .tx_packet_data(tx_packet_data), .tx_packet_data_size(tx_packet_data_size),
        .buffer_full(buffer_full), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model advances at the same edge the DUT does.
    task automatic step(input logic st, input logic [31:0] d, input logic [2:0] c,
                        input logic clr, input logic gt);
        int n;
        int pre;
        logic req;
        store_tx_data = st; tx_data = d; tx_byte_cnt = c; clear = clr; get_tx_packet_data = gt;
        @(posedge clk);
        n = int'(c);
        req = st && (n >= 1) && (n <= 4);
        e_ovf = 1'b0;
        e_unf = 1'b0;
        if (clr) begin
            q.delete();
        end else begin
            pre = q.size();
            if (gt) begin
                if (pre > 0) void'(q.pop_front());
                else e_unf = 1'b1;
            end
            if (req && (n <= 64 - pre)) begin
                for (int k = 0; k < n; k++) q.push_back(d[8*k +: 8]);
            end else if (req) begin
                e_ovf = 1'b1;
            end
        end
        #1;
        store_tx_data = 1'b0; tx_data = 32'd0; tx_byte_cnt = 3'd0; clear = 1'b0; get_tx_packet_data = 1'b0;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_data", {24'd0, tx_packet_data}, (q.size() > 0) ? {24'd0, q[0]} : 32'd0);
            chk("m_size", {25'd0, tx_packet_data_size}, 32'(q.size()));
            chk("m_full", {31'd0, buffer_full}, {31'd0, (q.size() == 64)});
            chk("m_ovf", {31'd0, overflow_err}, {31'd0, e_ovf});
            chk("m_unf", {31'd0, underflow_err}, {31'd0, e_unf});
        end
    end

    initial begin
        #1;
        chk("rst_data", {24'd0, tx_packet_data}, 32'h0);
        chk("rst_size", {25'd0, tx_packet_data_size}, 32'd0);
        chk("rst_flags", {29'd0, buffer_full, overflow_err, underflow_err}, 32'd0);
        #13 n_rst = 1'b1;
        #2 chk_en = 1'b1;

        // Word write then byte pops
        step(1'b1, 32'h44332211, 3'd4, 1'b0, 1'b0);
        chk("word_size", {25'd0, tx_packet_data_size}, 32'd4);
        chk("word_b0", {24'd0, tx_packet_data}, 32'h11);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        chk("word_b1", {24'd0, tx_packet_data}, 32'h22);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        chk("word_b2", {24'd0, tx_packet_data}, 32'h33);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        chk("word_b3", {24'd0, tx_packet_data}, 32'h44);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        chk("word_empty", {17'd0, tx_packet_data, tx_packet_data_size}, 32'd0);

        // Invalid byte counts are no-ops
        step(1'b1, 32'h12345678, 3'd0, 1'b0, 1'b0);
        step(1'b1, 32'h12345678, 3'd5, 1'b0, 1'b0);
        chk("badcnt_size", {25'd0, tx_packet_data_size}, 32'd0);

        // Fill to 64 then overflow
        for (int i = 0; i < 16; i++) begin
            step(1'b1, {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)}, 3'd4, 1'b0, 1'b0);
        end
        chk("fill_full", {31'd0, buffer_full}, 32'd1);
        chk("fill_size", {25'd0, tx_packet_data_size}, 32'd64);
        step(1'b1, 32'h000000FF, 3'd1, 1'b0, 1'b0);
        chk("ovf_pulse", {31'd0, overflow_err}, 32'd1);
        chk("ovf_head", {24'd0, tx_packet_data}, 32'h01);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        chk("ovf_drop", {31'd0, overflow_err}, 32'd0);

        // Simultaneous pop+write at 64 (rejected) and at 63 (accepted)
        step(1'b1, 32'h000000DD, 3'd1, 1'b0, 1'b1);
        chk("sim64_ovf", {31'd0, overflow_err}, 32'd1);
        chk("sim64_size", {25'd0, tx_packet_data_size}, 32'd63);
        step(1'b1, 32'h000000EE, 3'd1, 1'b0, 1'b1);
        chk("sim63_ovf", {31'd0, overflow_err}, 32'd0);
        chk("sim63_size", {25'd0, tx_packet_data_size}, 32'd63);
        chk("sim63_head", {24'd0, tx_packet_data}, 32'h03);
        for (int i = 0; i < 62; i++) step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        chk("sim_tail", {24'd0, tx_packet_data}, 32'hEE);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);

        // Wrap across index 63 -> 0
        step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 32'h5A5A5A5A, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 32'hA3A2A1A0, 3'd4, 1'b0, 1'b0);
        step(1'b1, 32'hA7A6A5A4, 3'd4, 1'b0, 1'b0);
        chk("wrap_size", {25'd0, tx_packet_data_size}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_byte", {24'd0, tx_packet_data}, 32'(8'hA0 + 8'(i)));
            step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        end

        // Clear beats write and pop; then underflow
        step(1'b1, 32'h04030201, 3'd4, 1'b0, 1'b0);
        step(1'b1, 32'h00000005, 3'd1, 1'b0, 1'b0);
        chk("clr_pre", {25'd0, tx_packet_data_size}, 32'd5);
        step(1'b1, 32'hFFFFFFFF, 3'd4, 1'b1, 1'b1);
        chk("clr_size", {25'd0, tx_packet_data_size}, 32'd0);
        chk("clr_noerr", {30'd0, overflow_err, underflow_err}, 32'd0);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        chk("unf_pulse", {31'd0, underflow_err}, 32'd1);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        chk("unf_drop", {31'd0, underflow_err}, 32'd0);

        // Asynchronous reset mid-operation at occupancy 10
        step(1'b1, 32'h13121110, 3'd4, 1'b0, 1'b0);
        step(1'b1, 32'h17161514, 3'd4, 1'b0, 1'b0);
        step(1'b1, 32'h00001918, 3'd2, 1'b0, 1'b0);
        chk("ar_pre", {25'd0, tx_packet_data_size}, 32'd10);
        #2;
        chk_en = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("ar_data", {24'd0, tx_packet_data}, 32'h0);
        chk("ar_size", {25'd0, tx_packet_data_size}, 32'd0);
        chk("ar_flags", {29'd0, buffer_full, overflow_err, underflow_err}, 32'd0);
        q.delete();
        e_ovf = 1'b0;
        e_unf = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        #1 chk_en = 1'b1;
        step(1'b1, 32'h000000C1, 3'd1, 1'b0, 1'b0);
        chk("post_rst", {24'd0, tx_packet_data}, 32'hC1);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
